// File: rtl/gm_packet_pkg.sv
// Shared definitions for the sync-byte packet framer.
package gm_packet_pkg;

  // FSM state encodings
  localparam logic [2:0] ST_HUNT = 3'd0;
  localparam logic [2:0] ST_D0   = 3'd1;
  localparam logic [2:0] ST_D1   = 3'd2;
  localparam logic [2:0] ST_D2   = 3'd3;
  localparam logic [2:0] ST_CHK  = 3'd4;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  // packet_out field positions: {seq, byte0, byte1, byte2}
  localparam int SEQ_MSB = 31;
  localparam int B0_MSB  = 23;
  localparam int B1_MSB  = 15;
  localparam int B2_MSB  = 7;

  // Frame checksum is a plain XOR of the three data bytes
  function automatic logic [7:0] frame_csum(input logic [7:0] b0,
                                            input logic [7:0] b1,
                                            input logic [7:0] b2);
    return b0 ^ b1 ^ b2;
  endfunction

endpackage

// File: rtl/byte_timeout_timer.sv
// Inter-byte gap timer. Counts idle cycles while run=1 and flags the
// cycle in which the gap reaches TIMEOUT_CYCLES. clr has priority, so a
// byte arriving in the final cycle suppresses the expiry.
module byte_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int TMR_W          = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic run,
  output logic expired
);

  localparam logic [TMR_W-1:0] LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  logic [TMR_W-1:0] cnt;

  assign expired = run & ~clr & (cnt == LAST);

  // Idle-cycle counter; restarts on a byte, on leaving the frame, or on expiry
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)            cnt <= '0;
    else if (clr || expired) cnt <= '0;
    else if (run)            cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/packet_assembler.sv
// Byte-stream framer: SYNC, three data bytes, XOR checksum. Each good frame
// publishes {seq, b0, b1, b2} as a held word with a one-cycle strobe.
// reset_n is expected to be released synchronously to clk upstream.
module packet_assembler
  import gm_packet_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF,
  parameter int         TIMEOUT_CYCLES = 50000,
  parameter int         TMR_W          = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        clear_err,
  output logic [31:0] packet_out,
  output logic        packet_strobe,
  output logic [7:0]  err_count,
  output logic        busy
);

  logic [2:0] state;
  logic [7:0] byte0, byte1, byte2;
  logic [7:0] seq;
  logic       in_frame;
  logic       expired;
  logic       csum_ok;
  logic       csum_bad;
  logic       err_evt;

  assign in_frame = (state != ST_HUNT);
  assign busy     = in_frame;
  assign csum_ok  = (rx_data == frame_csum(byte0, byte1, byte2));
  assign csum_bad = rx_valid & (state == ST_CHK) & ~csum_ok;
  assign err_evt  = csum_bad | expired;

  byte_timeout_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TMR_W          (TMR_W)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (rx_valid | ~in_frame),
    .run     (in_frame & ~rx_valid),
    .expired (expired)
  );

  // Frame FSM, shadow bytes and atomic publish of the output word
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_HUNT;
      byte0         <= '0;
      byte1         <= '0;
      byte2         <= '0;
      seq           <= '0;
      packet_out    <= '0;
      packet_strobe <= 1'b0;
    end else begin
      packet_strobe <= 1'b0;
      if (expired) begin
        state <= ST_HUNT;
      end else if (rx_valid) begin
        case (state)
          ST_HUNT: if (rx_data == SYNC_BYTE) state <= ST_D0;
          ST_D0:   begin byte0 <= rx_data; state <= ST_D1;  end
          ST_D1:   begin byte1 <= rx_data; state <= ST_D2;  end
          ST_D2:   begin byte2 <= rx_data; state <= ST_CHK; end
          ST_CHK: begin
            if (csum_ok) begin
              packet_out[SEQ_MSB -: 8] <= seq + 8'd1;
              packet_out[B0_MSB  -: 8] <= byte0;
              packet_out[B1_MSB  -: 8] <= byte1;
              packet_out[B2_MSB  -: 8] <= byte2;
              seq                      <= seq + 8'd1;
              packet_strobe            <= 1'b1;
            end
            state <= ST_HUNT;
          end
          default: state <= ST_HUNT;
        endcase
      end
    end
  end

  // Saturating bad-frame counter; a clear beats a same-cycle error
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                        err_count <= '0;
    else if (clear_err)                  err_count <= '0;
    else if (err_evt && err_count != 8'hFF) err_count <= err_count + 8'd1;
  end

endmodule

// File: tb/tb_packet_assembler.sv
// Directed bench for packet_assembler: per-cycle vector table for the basic
// framing cases, then hand-written sequences for timeout, wrap/saturation
// and mid-frame reset.
module tb_packet_assembler;

  localparam int TO = 20;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        clear_err;
  logic [31:0] packet_out;
  logic        packet_strobe;
  logic [7:0]  err_count;
  logic        busy;

  int total = 0;
  int bad   = 0;

  packet_assembler #(
    .SYNC_BYTE      (8'hA5),
    .TIMEOUT_CYCLES (TO),
    .TMR_W          (5)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .rx_valid      (rx_valid),
    .rx_data       (rx_data),
    .clear_err     (clear_err),
    .packet_out    (packet_out),
    .packet_strobe (packet_strobe),
    .err_count     (err_count),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        c;
    logic [31:0] pkt;
    logic        stb;
    logic [7:0]  err;
    logic        bsy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic v, logic [7:0] d, logic c, logic [31:0] pkt,
                              logic stb, logic [7:0] err, logic bsy);
    vec_t r;
    r.v = v; r.d = d; r.c = c; r.pkt = pkt; r.stb = stb; r.err = err; r.bsy = bsy;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs, clock them in, and return #1 after the edge
  task automatic apply(input logic v, input logic [7:0] d, input logic c);
    rx_valid  = v;
    rx_data   = d;
    clear_err = c;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply(1'b0, 8'h00, 1'b0);
  endtask

  task automatic frame(input logic [7:0] b0, input logic [7:0] b1,
                       input logic [7:0] b2, input logic [7:0] ck);
    apply(1'b1, 8'hA5, 1'b0);
    apply(1'b1, b0, 1'b0);
    apply(1'b1, b1, 1'b0);
    apply(1'b1, b2, 1'b0);
    apply(1'b1, ck, 1'b0);
  endtask

  int strobes;

  initial begin
    reset_n   = 1'b0;
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    clear_err = 1'b0;

    // ---- reset state
    #12;
    chk("rst_pkt",  packet_out,    32'h0);
    chk("rst_stb",  {31'b0, packet_strobe}, 32'h0);
    chk("rst_err",  {24'b0, err_count},     32'h0);
    chk("rst_busy", {31'b0, busy},          32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // ---- table: good frame, bad checksum, noise + embedded sync, clear
    // good frame: 12^34^56 = 70
    vecs.push_back(mk(1, 8'hA5, 0, 32'h00000000, 0, 8'd0, 1));
    vecs.push_back(mk(1, 8'h12, 0, 32'h00000000, 0, 8'd0, 1));
    vecs.push_back(mk(1, 8'h34, 0, 32'h00000000, 0, 8'd0, 1));
    vecs.push_back(mk(1, 8'h56, 0, 32'h00000000, 0, 8'd0, 1));
    vecs.push_back(mk(1, 8'h70, 0, 32'h01123456, 1, 8'd0, 0));
    vecs.push_back(mk(0, 8'h00, 0, 32'h01123456, 0, 8'd0, 0));
    // bad checksum
    vecs.push_back(mk(1, 8'hA5, 0, 32'h01123456, 0, 8'd0, 1));
    vecs.push_back(mk(1, 8'h12, 0, 32'h01123456, 0, 8'd0, 1));
    vecs.push_back(mk(0, 8'h00, 0, 32'h01123456, 0, 8'd0, 1));
    vecs.push_back(mk(1, 8'h34, 0, 32'h01123456, 0, 8'd0, 1));
    vecs.push_back(mk(1, 8'h56, 0, 32'h01123456, 0, 8'd0, 1));
    vecs.push_back(mk(1, 8'h71, 0, 32'h01123456, 0, 8'd1, 0));
    // noise then a frame whose first data byte equals the sync byte
    vecs.push_back(mk(1, 8'h00, 0, 32'h01123456, 0, 8'd1, 0));
    vecs.push_back(mk(1, 8'hFF, 0, 32'h01123456, 0, 8'd1, 0));
    vecs.push_back(mk(1, 8'hA5, 0, 32'h01123456, 0, 8'd1, 1));
    vecs.push_back(mk(1, 8'hA5, 0, 32'h01123456, 0, 8'd1, 1));
    vecs.push_back(mk(1, 8'h00, 0, 32'h01123456, 0, 8'd1, 1));
    vecs.push_back(mk(1, 8'h00, 0, 32'h01123456, 0, 8'd1, 1));
    vecs.push_back(mk(1, 8'hA5, 0, 32'h02A50000, 1, 8'd1, 0));
    // clear
    vecs.push_back(mk(0, 8'h00, 1, 32'h02A50000, 0, 8'd0, 0));

    foreach (vecs[i]) begin
      apply(vecs[i].v, vecs[i].d, vecs[i].c);
      chk($sformatf("vec%0d_pkt", i),  packet_out, vecs[i].pkt);
      chk($sformatf("vec%0d_stb", i),  {31'b0, packet_strobe}, {31'b0, vecs[i].stb});
      chk($sformatf("vec%0d_err", i),  {24'b0, err_count},     {24'b0, vecs[i].err});
      chk($sformatf("vec%0d_busy", i), {31'b0, busy},          {31'b0, vecs[i].bsy});
    end

    // ---- timeout: gap of TO idle cycles after a data byte
    apply(1'b1, 8'hA5, 1'b0);
    apply(1'b1, 8'h12, 1'b0);
    idle(TO - 1);
    chk("to_pre_busy", {31'b0, busy},      32'h1);
    chk("to_pre_err",  {24'b0, err_count}, 32'h0);
    idle(1);
    chk("to_busy", {31'b0, busy},      32'h0);
    chk("to_err",  {24'b0, err_count}, 32'h1);
    chk("to_pkt",  packet_out,         32'h02A50000);

    // ---- byte arriving in the timeout cycle wins
    apply(1'b1, 8'hA5, 1'b0);
    apply(1'b1, 8'h12, 1'b0);
    idle(TO - 1);
    apply(1'b1, 8'h34, 1'b0);
    chk("tw_busy", {31'b0, busy},      32'h1);
    chk("tw_err",  {24'b0, err_count}, 32'h1);
    apply(1'b1, 8'h56, 1'b0);
    apply(1'b1, 8'h70, 1'b0);
    chk("tw_pkt", packet_out,              32'h03123456);
    chk("tw_stb", {31'b0, packet_strobe},  32'h1);
    chk("tw_err2", {24'b0, err_count},     32'h1);

    // ---- seq wrap: seq is 3, 253 more good frames land on 00
    strobes = 0;
    for (int i = 0; i < 253; i++) begin
      frame(8'h12, 8'h34, 8'h56, 8'h70);
      if (packet_strobe) strobes++;
    end
    chk("wrap_strobes", strobes,    32'd253);
    chk("wrap_pkt",     packet_out, 32'h00123456);
    frame(8'h01, 8'h02, 8'h03, 8'h00);
    chk("wrap_next", packet_out, 32'h01010203);

    // ---- saturation
    apply(1'b0, 8'h00, 1'b1);
    chk("sat_clr", {24'b0, err_count}, 32'h0);
    for (int i = 0; i < 300; i++) frame(8'h12, 8'h34, 8'h56, 8'h71);
    chk("sat_err", {24'b0, err_count}, 32'hFF);
    chk("sat_pkt", packet_out,         32'h01010203);

    // ---- clear coincident with a checksum error
    apply(1'b1, 8'hA5, 1'b0);
    apply(1'b1, 8'h12, 1'b0);
    apply(1'b1, 8'h34, 1'b0);
    apply(1'b1, 8'h56, 1'b0);
    apply(1'b1, 8'h71, 1'b1);
    chk("clr_win_err",  {24'b0, err_count}, 32'h0);
    chk("clr_win_busy", {31'b0, busy},      32'h0);
    apply(1'b0, 8'h00, 1'b0);

    // ---- reset mid-frame
    frame(8'h12, 8'h34, 8'h56, 8'h71);
    chk("mr_pre_err", {24'b0, err_count}, 32'h1);
    apply(1'b1, 8'hA5, 1'b0);
    apply(1'b1, 8'h12, 1'b0);
    apply(1'b1, 8'h34, 1'b0);
    rx_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("mr_pkt",  packet_out,              32'h0);
    chk("mr_stb",  {31'b0, packet_strobe},  32'h0);
    chk("mr_err",  {24'b0, err_count},      32'h0);
    chk("mr_busy", {31'b0, busy},           32'h0);
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    idle(1);
    frame(8'hDE, 8'hAD, 8'hBE, 8'hDE ^ 8'hAD ^ 8'hBE);
    chk("mr_new_pkt", packet_out,             32'h01DEADBE);
    chk("mr_new_stb", {31'b0, packet_strobe}, 32'h1);
    idle(1);
    chk("mr_stb_drop", {31'b0, packet_strobe}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
